// File: rtl/voice_env_mixer.sv
// Sequential voice mixer: one voice per clock, each scaled by its own decaying
// envelope, producing one saturated 8-bit unsigned sample per NVOICES+2 clock frame.
module voice_env_mixer #(
    parameter int NVOICES     = 4,
    parameter int DECAY_SHIFT = 16,
    parameter int ENV_FLOOR   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7*NVOICES-1:0]   sample_in,
    input  logic [NVOICES-1:0]     voice_en,
    input  logic [NVOICES-1:0]     note_on,
    output logic [7:0]             mix_out,
    output logic                   mix_valid
);
    localparam int PH_W  = $clog2(NVOICES + 2);
    localparam int ACC_W = $clog2(NVOICES) + 8;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NVOICES + 1);

    logic [PH_W-1:0]         phase_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [DECAY_SHIFT-1:0]  prescaler_reg;
    logic                    tick;
    logic [4*NVOICES-1:0]    env_flat;

    assign tick = &prescaler_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prescaler_reg <= '0;
        else
            prescaler_reg <= prescaler_reg + 1'b1;
    end

    // Retrigger wins over a coincident decay tick; decay stops at the floor.
    for (genvar gi = 0; gi < NVOICES; gi++) begin : g_env
        logic [3:0] env_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                env_reg <= 4'd0;
            else if (note_on[gi])
                env_reg <= 4'd15;
            else if (tick && (env_reg > 4'(ENV_FLOOR)))
                env_reg <= env_reg - 4'd1;
        end
        assign env_flat[4*gi +: 4] = env_reg;
    end

    logic [6:0] cur_sample;
    logic [3:0] cur_env;
    logic       cur_en;

    always_comb begin
        cur_sample = 7'd64;
        cur_env    = 4'd0;
        cur_en     = 1'b0;
        for (int k = 0; k < NVOICES; k++) begin
            if (phase_reg == PH_W'(k + 1)) begin
                cur_sample = sample_in[7*k +: 7];
                cur_env    = env_flat[4*k +: 4];
                cur_en     = voice_en[k];
            end
        end
    end

    logic signed [7:0]       centered;
    logic signed [12:0]      product;
    logic signed [8:0]       scaled;
    logic signed [ACC_W-1:0] contrib;

    assign centered = $signed({1'b0, cur_sample}) - 8'sd64;
    assign product  = 13'(centered) * 13'($signed({1'b0, cur_env}));
    assign scaled   = 9'(product >>> 4);
    assign contrib  = cur_en ? ACC_W'(scaled) : '0;

    logic signed [ACC_W:0] biased;
    logic [7:0]            sat;

    assign biased = (ACC_W+1)'(acc_reg >>> 1) + (ACC_W+1)'(128);

    always_comb begin
        sat = biased[7:0];
        if (biased[ACC_W])
            sat = 8'h00;
        else if (biased > (ACC_W+1)'(255))
            sat = 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
            acc_reg   <= '0;
            mix_out   <= 8'h80;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (phase_reg == LAST_PH) begin
                phase_reg <= '0;
                mix_out   <= sat;
                mix_valid <= 1'b1;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
            if (phase_reg == '0)
                acc_reg <= '0;
            else if (phase_reg != LAST_PH)
                acc_reg <= acc_reg + contrib;
        end
    end
endmodule

// File: tb/tb_voice_env_mixer.sv
// Bench for voice_env_mixer: frame-level reference model checked every cycle,
// plus hand-computed mix values for the directed scenarios.
module tb_voice_env_mixer;
    localparam int NV    = 4;
    localparam int DS    = 4;
    localparam int FLOOR = 4;
    localparam int FRAME = NV + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7*NV-1:0] sample_in;
    logic [NV-1:0] voice_en;
    logic [NV-1:0] note_on;
    logic [7:0]    mix_out;
    logic          mix_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int frames = 0;

    voice_env_mixer #(.NVOICES(NV), .DECAY_SHIFT(DS), .ENV_FLOOR(FLOOR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_in (sample_in),
        .voice_en  (voice_en),
        .note_on   (note_on),
        .mix_out   (mix_out),
        .mix_valid (mix_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference model: edges counted since reset give both the frame phase and
    // the decay ticks; each frame is a sum of floor(c*env/16) terms.
    int m_cyc = 0;
    int m_acc = 0;
    int m_out = 128;
    bit m_valid = 1'b0;
    int m_env[NV];
    int m_p;
    int m_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_acc = 0; m_out = 128; m_valid = 1'b0;
            for (int k = 0; k < NV; k++) m_env[k] = 0;
        end else begin
            m_p = m_cyc % FRAME;
            m_valid = 1'b0;
            if (m_p == 0) begin
                m_acc = 0;
            end else if (m_p <= NV) begin
                m_v = m_p - 1;
                if (voice_en[m_v])
                    m_acc += fdiv((int'(sample_in[7*m_v +: 7]) - 64) * m_env[m_v], 16);
            end else begin
                m_valid = 1'b1;
                m_out = fdiv(m_acc, 2) + 128;
                if (m_out < 0) m_out = 0;
                if (m_out > 255) m_out = 255;
            end
            for (int k = 0; k < NV; k++) begin
                if (note_on[k]) m_env[k] = 15;
                else if ((m_cyc % (1 << DS)) == (1 << DS) - 1 && m_env[k] > FLOOR) m_env[k]--;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mix_valid", int'(mix_valid), int'(m_valid));
            check("mix_out", int'(mix_out), m_out);
            if (m_valid) begin
                frames++;
                $display("frame %0d: mix_out=%02h model=%02h", frames, mix_out, m_out[7:0]);
            end
        end
    end

    task automatic wait_strobe();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (mix_valid) seen = 1'b1;
        end
        if (!seen) check("strobe_timeout", 0, 1);
    endtask

    task automatic expect_frame(input string name, input int exp);
        wait_strobe();
        wait_strobe();
        check(name, int'(mix_out), exp);
        $display("%s: mix_out=%02h expected %02h", name, mix_out, exp[7:0]);
    endtask

    task automatic first_strobe(input string name);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 3 * FRAME && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mix_valid) begin seen = 1'b1; n = i; end
        end
        check(name, n, FRAME);
        @(negedge clk);
    endtask

    initial begin
        sample_in = '0;
        voice_en  = '0;
        note_on   = '0;
        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_mix_out", int'(mix_out), 8'h80);
        check("reset_mix_valid", int'(mix_valid), 0);
        repeat (3) @(negedge clk);

        // Envelopes are zero after reset: output stays at silence.
        sample_in = 28'($urandom);
        voice_en  = 4'hF;
        rst_n     = 1'b1;
        first_strobe("first_strobe_edge");
        expect_frame("silent_env0", 8'h80);

        // Envelopes held at full scale by a continuous retrigger.
        note_on   = 4'hF;
        sample_in = {7'd64, 7'd64, 7'd64, 7'd127};
        expect_frame("voice0_full", 157);
        sample_in = {4{7'd0}};
        expect_frame("all_min", 8);
        sample_in = {4{7'd127}};
        expect_frame("all_max", 246);
        sample_in = {7'd64, 7'd64, 7'd0, 7'd64};
        voice_en  = 4'b1101;
        expect_frame("voice1_disabled", 8'h80);
        voice_en  = 4'b1111;
        expect_frame("voice1_enabled", 8'h80 - 30);

        // Decay from 15 down to the floor, then hold.
        sample_in = {7'd64, 7'd64, 7'd64, 7'd127};
        note_on   = 4'h1;
        @(negedge clk);
        note_on   = 4'h0;
        repeat (16 * 13) @(negedge clk);
        expect_frame("decayed_floor", 135);

        // Random traffic, retriggers sprinkled in.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            sample_in = 28'($urandom);
            if ($urandom_range(0, 9) == 0) sample_in = {4{7'($urandom_range(0, 1) * 127)}};
            voice_en = 4'($urandom);
            for (int k = 0; k < NV; k++) note_on[k] = ($urandom_range(0, 7) == 0);
        end

        // Asynchronous reset in the middle of a frame.
        note_on   = 4'hF;
        voice_en  = 4'hF;
        sample_in = {4{7'd127}};
        expect_frame("pre_reset_max", 246);
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != 3; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mix_out", int'(mix_out), 8'h80);
        check("async_reset_mix_valid", int'(mix_valid), 0);
        note_on = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first_strobe("post_reset_first_strobe");
        expect_frame("post_reset_silent", 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
